// File: rtl/cargador_programa_if.sv
// Byte-stream ingress and instruction-memory write bus of the program loader.
interface cargador_programa_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_byte;
    logic                  in_last;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        output in_valid, in_byte, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cargador_programa.sv
// Boot loader: packs a little-endian byte stream into instruction words, writes
// them to imem and keeps the core in reset until loading plus a hold time ends.
module cargador_programa #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cargador_programa_if.slave    bus,
    input  logic                  reload,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  err_overflow,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HW  = $clog2(RESET_HOLD + 1);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {LOAD, HOLD, RUN, ERR} state_t;

    state_t                state, state_nx;
    logic [BIW-1:0]        byte_idx;
    logic [DATA_WIDTH-1:0] asm_q, asm_nx;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [HW-1:0]         hold_cnt;
    logic                  xfer, word_done, overflow;

    always_comb begin
        xfer      = bus.in_valid && bus.in_ready;
        word_done = xfer && (bus.in_last || byte_idx == BIW'(BPW - 1));
        overflow  = word_done && (wr_ptr == MAX_WORDS);
        // Lanes above byte_idx are always zero, so partial words come out padded.
        asm_nx = asm_q;
        asm_nx[8*int'(byte_idx) +: 8] = bus.in_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: begin
                if (overflow)                   state_nx = ERR;
                else if (xfer && bus.in_last)   state_nx = HOLD;
            end
            HOLD: if (hold_cnt == '0) state_nx = RUN;
            RUN:  if (reload)         state_nx = LOAD;
            ERR:  state_nx = ERR;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == LOAD);
        cpu_reset    = (state != RUN);
        done         = (state == RUN);
        err_overflow = (state == ERR);
    end

    assign word_count = wr_ptr;

    // Counting down to zero keeps HOLD for RESET_HOLD cycles beyond the final write strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx       <= '0;
            asm_q          <= '0;
            wr_ptr         <= '0;
            hold_cnt       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (state == RUN && reload) begin
                wr_ptr   <= '0;
                byte_idx <= '0;
                asm_q    <= '0;
            end
            if (xfer) begin
                if (word_done) begin
                    byte_idx <= '0;
                    asm_q    <= '0;
                    if (!overflow) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= wr_ptr[ADDR_WIDTH-1:0];
                        bus.imem_wdata <= asm_nx;
                        wr_ptr         <= wr_ptr + (ADDR_WIDTH+1)'(1);
                    end
                end else begin
                    byte_idx <= byte_idx + BIW'(1);
                    asm_q    <= asm_nx;
                end
                if (bus.in_last) hold_cnt <= HW'(RESET_HOLD);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cargador_programa.sv
// Directed bench for cargador_programa with a byte-level scoreboard model
// checked against the DUT on every cycle.
module tb_cargador_programa;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RH = 2;
    localparam int MAXW = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reload = 1'b0;
    logic cpu_reset, done, err_overflow;
    logic [AW:0] word_count;

    cargador_programa_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cargador_programa #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .reload(reload),
        .cpu_reset(cpu_reset), .done(done), .err_overflow(err_overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int nwr = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    // Spec-level model: expected writes, load progress and release cycle.
    logic [AW+DW-1:0] exp_q[$];
    logic [7:0]       part[$];
    int mdl_ptr = 0;
    bit mdl_err = 1'b0;
    bit mdl_loading = 1'b1;
    int rel_at = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input bit last);
        logic [DW-1:0] w;
        part.push_back(b);
        if (part.size() == DW/8 || last) begin
            w = '0;
            foreach (part[j]) w[8*j +: 8] = part[j];
            part.delete();
            if (mdl_ptr == MAXW) begin
                mdl_err = 1'b1;
                mdl_loading = 1'b0;
                rel_at = -1;
            end else begin
                exp_q.push_back({AW'(mdl_ptr), w});
                mdl_ptr++;
            end
        end
        if (last && !mdl_err) begin
            mdl_loading = 1'b0;
            rel_at = ncyc + 1 + RH + 1;
        end
    endtask

    initial begin
        bit exp_run;
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            ncyc++;
            exp_run = (rel_at >= 0) && (ncyc >= rel_at);
            chk("in_ready", bus.in_ready, mdl_loading);
            chk("cpu_reset", cpu_reset, !exp_run);
            chk("done", done, exp_run);
            chk("err_overflow", err_overflow, mdl_err);
            chk("word_count", word_count, mdl_ptr);
            if (bus.imem_we) begin
                nwr++;
                last_addr = bus.imem_addr;
                last_data = bus.imem_wdata;
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("imem_addr", bus.imem_addr, e[AW+DW-1:DW]);
                    chk("imem_wdata", bus.imem_wdata, e[DW-1:0]);
                end
            end else if (exp_q.size() != 0) begin
                chk("we_missing", 1'b0, 1'b1);
                exp_q.delete();
            end
        end
    end

    task automatic send(input logic [7:0] b[$], input bit last_on_end, input bit bubbles);
        bit acc;
        for (int i = 0; i < b.size(); i++) begin
            if (bubbles) begin
                bus.in_valid = 1'b0; bus.in_byte = 8'hFF; bus.in_last = 1'b1;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_byte  = b[i];
            bus.in_last  = last_on_end && (i == b.size() - 1);
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                if (acc) model_accept(b[i], bus.in_last);
                #1;
            end
            if (!acc) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_reload();
        bit was_run;
        was_run = (rel_at >= 0) && (ncyc + 1 >= rel_at);
        reload = 1'b1;
        @(posedge clk);
        if (was_run) begin
            mdl_ptr = 0; part.delete(); rel_at = -1; mdl_loading = 1'b1;
        end
        #1 reload = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        @(posedge clk);
        mdl_ptr = 0; part.delete(); exp_q.delete();
        mdl_err = 1'b0; mdl_loading = 1'b1; rel_at = -1;
        #1 reset = 1'b1;
    endtask

    task automatic wait_run();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("released", done, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] q[$];
        int w0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_imem_addr", bus.imem_addr, 0);
        chk("rst_imem_wdata", bus.imem_wdata, 0);
        @(posedge clk); #1;

        // Single word, release exactly RH+1 edges after the last byte.
        q = '{8'h13, 8'h05, 8'h10, 8'h00};
        send(q, 1'b1, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("t1_hold_cpu_reset", cpu_reset, 1'b1);
        @(negedge clk);
        chk("t1_release_cpu_reset", cpu_reset, 1'b0);
        chk("t1_done", done, 1'b1);
        chk("t1_word_count", word_count, 1);
        chk("t1_data", last_data, 32'h00100513);
        chk("t1_addr", last_addr, 0);
        @(posedge clk); #1;

        // Two back-to-back words.
        do_reload();
        w0 = nwr;
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send(q, 1'b1, 1'b0);
        wait_run();
        chk("t2_writes", nwr - w0, 2);
        chk("t2_data", last_data, 32'h08070605);
        chk("t2_addr", last_addr, 1);

        // Partial final word is zero padded.
        do_reload();
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send(q, 1'b1, 1'b0);
        wait_run();
        chk("t3_data", last_data, 32'h000000EE);
        chk("t3_word_count", word_count, 2);

        // Overflow: 17 words into a 16-word memory.
        do_reload();
        w0 = nwr;
        q.delete();
        for (int i = 0; i < (MAXW + 1) * 4; i++) q.push_back(8'(i + 1));
        send(q, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_writes", nwr - w0, 16);
        chk("t4_last_addr", last_addr, 15);
        chk("t4_err", err_overflow, 1'b1);
        do_reload();
        @(negedge clk);
        chk("t4_err_after_reload", err_overflow, 1'b1);
        chk("t4_cpu_reset", cpu_reset, 1'b1);
        chk("t4_in_ready", bus.in_ready, 1'b0);
        chk("t4_word_count", word_count, 16);
        @(posedge clk); #1;

        // Reload from RUN restarts at address 0.
        reset_dut();
        q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send(q, 1'b1, 1'b0);
        wait_run();
        do_reload();
        @(negedge clk);
        chk("t5_reload_cpu_reset", cpu_reset, 1'b1);
        chk("t5_word_count_clr", word_count, 0);
        @(posedge clk); #1;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(q, 1'b1, 1'b0);
        wait_run();
        chk("t5_data", last_data, 32'h44332211);
        chk("t5_addr", last_addr, 0);
        chk("t5_word_count", word_count, 1);

        // Bubbles, then reset mid-word abandons the partial word.
        reset_dut();
        w0 = nwr;
        q = '{8'h01, 8'h02};
        send(q, 1'b0, 1'b1);
        reset_dut();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_write", nwr - w0, 0);
        chk("t6_word_count", word_count, 0);
        chk("t6_in_ready", bus.in_ready, 1'b1);
        q = '{8'h55, 8'h66, 8'h77, 8'h88};
        send(q, 1'b1, 1'b1);
        wait_run();
        chk("t6_data", last_data, 32'h88776655);
        chk("t6_addr", last_addr, 0);
        chk("t6_writes", nwr - w0, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
